fixed_point_subtractor_serial: RTL and testbench
================================================

FIXED_POINT_SUBTRACTOR_SERIAL -- requirements
Module: fixed_point_subtractor_serial

Interface
REQ-001 SHALL have parameter n1, default 8, integer bits of operand a.
REQ-002 SHALL have parameter m1, default 8, fractional bits of operand a.
REQ-003 SHALL have parameter n2, default 8, integer bits of operand b.
REQ-004 SHALL have parameter m2, default 8, fractional bits of operand b.
REQ-005 SHALL define N=max(n1,n2), M=max(m1,m2), W=N+M as derived widths (not ports).
REQ-006 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-007 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have start  input  1  request to begin a subtraction.
REQ-009 SHALL have a  input  n1+m1  unsigned fixed-point minuend, Q n1.m1.
REQ-010 SHALL have b  input  n2+m2  unsigned fixed-point subtrahend, Q n2.m2.
REQ-011 SHALL have busy  output  1  high while a subtraction is in progress.
REQ-012 SHALL have done  output  1  one-cycle pulse marking a valid result.
REQ-013 SHALL have diff  output  W+1  two's-complement result a-b, Q (N+1).M.
REQ-014 SHALL have neg  output  1  sign of the latest result (diff[W]).
REQ-015 SHALL have sat  output  1  saturation flag (see Configuration).

Function
REQ-016 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-017 IDLE: start=1 at a rising edge SHALL capture a and b, align them, clear the bit counter and borrow, and move to RUN.
REQ-018 Alignment SHALL zero-pad fractional parts on the right to M bits and zero-extend integer parts on the left to N bits, giving W-bit operands A and B.
REQ-019 RUN SHALL process one bit per cycle, LSB first, bits 0..W (bit W of A and B is 0), computing d_i = A_i ^ B_i ^ borrow and the next borrow as a full subtractor.
REQ-020 RUN SHALL last exactly W+1 cycles; after bit W it SHALL move to DONE.
REQ-021 DONE SHALL last one cycle with done=1, diff updated to the W+1-bit result, and neg=diff[W]; it SHALL then return to IDLE.
REQ-022 done SHALL therefore rise exactly W+2 cycles after the edge that sampled start (18 cycles with defaults).
REQ-023 busy SHALL be 1 in RUN only and 0 in IDLE and DONE.
REQ-024 start SHALL be ignored in RUN and DONE; a and b SHALL be ignored except at the capture edge.
REQ-025 diff, neg and sat SHALL hold their last values until the next DONE.
REQ-026 Back-to-back operation: start held high through DONE SHALL be accepted in the following IDLE cycle.
REQ-027 Equal operands SHALL give diff=0 and neg=0.
REQ-028 a=0, b=max SHALL give the most negative result without overflow, because W+1 bits cover the full range.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state=IDLE, busy=0, done=0, diff=0, neg=0, sat=0, and clear the bit counter, borrow and operand registers.
REQ-030 Reset during RUN SHALL abort the operation, produce no done pulse, and leave diff=0.
REQ-031 After rst_n deasserts, the first start SHALL be honoured at the first rising edge at which it is sampled.

Configuration
REQ-032 Macro FXSUB_SATURATE_EN: when defined, a negative result SHALL be clamped in DONE to diff=0, neg=0, with sat=1 for that result; a non-negative result SHALL give sat=0.
REQ-033 Without FXSUB_SATURATE_EN, diff SHALL be the raw two's-complement result and sat SHALL be tied to 0.

Verification
REQ-034 Defaults, a=16'h0303, b=16'h0105, start pulse -> done 18 cycles later, diff=17'h001FE, neg=0, busy high for 17 cycles.
REQ-035 Defaults, a=16'h0000, b=16'h0001 -> diff=17'h1FFFF, neg=1; with FXSUB_SATURATE_EN -> diff=0, neg=0, sat=1.
REQ-036 Defaults, a=b=16'hFFFF -> diff=0, neg=0, sat=0.
REQ-037 n1=4, m1=4, n2=8, m2=8; a=8'h18 (1.5), b=16'h0100 (1.0) -> diff=17'h00080 (0.5).
REQ-038 Start, then rst_n=0 in RUN cycle 5 -> busy=0, diff=0 immediately, no done; a new start after release completes normally.
REQ-039 start held high continuously -> done pulses every 19 cycles, and start pulses during RUN have no effect.

Source files
------------

// File: rtl/fixed_point_subtractor_serial.sv
// fixed_point_subtractor_serial
// Bit-serial (LSB-first) subtractor for unsigned fixed-point operands
// a (Q n1.m1) and b (Q n2.m2). Both operands are aligned to a common
// Q N.M grid. The result is produced as a W+1-bit two's-complement
// value in Q (N+1).M, where N = max(n1,n2), M = max(m1,m2) and W = N+M.
//
// Timing: the edge that samples start captures the operands. RUN then
// processes bits 0..W, one bit per cycle. The registered outputs follow
// the FSM by one cycle, so done rises W+2 cycles after the capture edge
// and busy stays high for W+1 cycles.
//
// Optional feature macro: FXSUB_SATURATE_EN. When it is defined, negative
// results are clamped to zero and flagged on sat.
module fixed_point_subtractor_serial #(
  parameter int n1 = 8,
  parameter int m1 = 8,
  parameter int n2 = 8,
  parameter int m2 = 8
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                start,
  input  logic [n1+m1-1:0]                                    a,
  input  logic [n2+m2-1:0]                                    b,
  output logic                                                busy,
  output logic                                                done,
  output logic [((n1>n2)?n1:n2)+((m1>m2)?m1:m2):0]            diff,
  output logic                                                neg,
  output logic                                                sat
);

  localparam int N  = (n1 > n2) ? n1 : n2;
  localparam int M  = (m1 > m2) ? m1 : m2;
  localparam int W  = N + M;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nx_s;
  logic [W:0]      opa_r;
  logic [W:0]      opb_r;
  logic [W:0]      res_r;
  logic            borrow_r;
  logic [CW-1:0]   cnt_r;
  logic [W-1:0]    a_al_s;
  logic [W-1:0]    b_al_s;
  logic [1:0]      fs_s;

  // Full subtractor: returns {borrow_out, difference_bit}.
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bin);
    full_sub = {((~x) & y) | ((~(x ^ y)) & bin), x ^ y ^ bin};
  endfunction

  // Alignment: zero-extend the integer part on the left and zero-pad the
  // fraction on the right, which is a zero-extend followed by a left shift.
  assign a_al_s = W'(a) << (M - m1);
  assign b_al_s = W'(b) << (M - m2);

  // One bit of the subtraction per RUN cycle, using the current LSBs and borrow.
  assign fs_s = full_sub(opa_r[0], opb_r[0], borrow_r);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic. RUN covers counter values 0..W, which is W+1 cycles.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CW'(W)) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Serial datapath: capture the aligned operands, then shift out the LSBs
  // and shift the result bits in from the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_r    <= '0;
      opb_r    <= '0;
      res_r    <= '0;
      borrow_r <= 1'b0;
      cnt_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            opa_r    <= {1'b0, a_al_s};
            opb_r    <= {1'b0, b_al_s};
            res_r    <= '0;
            borrow_r <= 1'b0;
            cnt_r    <= '0;
          end
        end
        RUN: begin
          opa_r    <= opa_r >> 1;
          opb_r    <= opb_r >> 1;
          res_r    <= {fs_s[0], res_r[W:1]};
          borrow_r <= fs_s[1];
          cnt_r    <= cnt_r + CW'(1);
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Registered outputs. The result and its flags update only when leaving
  // DONE, and they hold their values between operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      diff <= '0;
      neg  <= 1'b0;
      sat  <= 1'b0;
    end else begin
      busy <= (state_r == RUN);
      done <= (state_r == DONE);
      if (state_r == DONE) begin
`ifdef FXSUB_SATURATE_EN
        if (res_r[W]) begin
          diff <= '0;
          neg  <= 1'b0;
          sat  <= 1'b1;
        end else begin
          diff <= res_r;
          neg  <= 1'b0;
          sat  <= 1'b0;
        end
`else
        diff <= res_r;
        neg  <= res_r[W];
        sat  <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fixed_point_subtractor_serial.sv
// Bench for fixed_point_subtractor_serial: table-driven vectors on the
// default configuration, plus reset-abort, back-to-back and mixed-format
// sequences. Expected values follow FXSUB_SATURATE_EN when it is defined.
module tb_fixed_point_subtractor_serial;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [16:0] diff;
  logic        neg;
  logic        sat;

  logic        start2;
  logic [7:0]  a2;
  logic [15:0] b2;
  logic        busy2;
  logic        done2;
  logic [16:0] diff2;
  logic        neg2;
  logic        sat2;

  int checks;
  int errors;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] d;
    logic        n;
  } vec_t;

  vec_t vecs[8];

  fixed_point_subtractor_serial dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .neg(neg), .sat(sat)
  );

  fixed_point_subtractor_serial #(.n1(4), .m1(4), .n2(8), .m2(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .diff(diff2), .neg(neg2), .sat(sat2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One full operation: pulse start, scramble the inputs after capture,
  // then check latency, busy length, result and flags.
  task automatic run_op(input logic [15:0] va, input logic [15:0] vb,
                        input logic [16:0] ed, input logic en, input string nm);
    int lat;
    int bcnt;
    bit seen;
    logic [16:0] xd;
    logic xn;
    logic xs;
    xd = ed;
    xn = en;
    xs = 1'b0;
`ifdef FXSUB_SATURATE_EN
    if (en) begin
      xd = 17'h0;
      xn = 1'b0;
      xs = 1'b1;
    end
`endif
    @(negedge clk);
    start = 1'b1;
    a = va;
    b = vb;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    lat = 0;
    bcnt = 0;
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (busy) bcnt++;
      if (done) begin
        seen = 1'b1;
        lat = k;
      end
    end
    chk({nm, " latency"}, lat, 18);
    chk({nm, " busy_cycles"}, bcnt, 17);
    chk({nm, " diff"}, diff, xd);
    chk({nm, " neg"}, neg, xn);
    chk({nm, " sat"}, sat, xs);
    @(posedge clk);
    #1;
    chk({nm, " done_pulse_end"}, done, 1'b0);
    chk({nm, " diff_hold"}, diff, xd);
  endtask

  initial begin
    int ndone;
    int nbusy;
    int edges[$];
    int lat2;
    bit seen2;
    checks = 0;
    errors = 0;

    vecs[0] = '{16'h0303, 16'h0105, 17'h001FE, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 17'h1FFFF, 1'b1};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 17'h00000, 1'b0};
    vecs[3] = '{16'h0000, 16'hFFFF, 17'h10001, 1'b1};
    vecs[4] = '{16'hFFFF, 16'h0000, 17'h0FFFF, 1'b0};
    vecs[5] = '{16'h8000, 16'h7FFF, 17'h00001, 1'b0};
    vecs[6] = '{16'h1234, 16'h5678, 17'h1BBBC, 1'b1};
    vecs[7] = '{16'hABCD, 16'h1234, 17'h09999, 1'b0};

    rst_n  = 1'b0;
    start  = 1'b0;
    a      = 16'h0;
    b      = 16'h0;
    start2 = 1'b0;
    a2     = 8'h0;
    b2     = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset diff", diff, 17'h0);
    chk("reset neg", neg, 1'b0);
    chk("reset sat", sat, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].n, $sformatf("vec%0d", i));
    end

    // Reset during RUN cycle 5 aborts the operation.
    @(negedge clk);
    start = 1'b1;
    a = 16'h0303;
    b = 16'h0105;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("abort busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 1'b0);
    chk("abort diff", diff, 17'h0);
    chk("abort done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    nbusy = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
      if (busy) nbusy++;
    end
    chk("abort no_done", ndone, 0);
    chk("abort no_busy", nbusy, 0);
    run_op(16'h0303, 16'h0105, 17'h001FE, 1'b0, "post_abort");

    // start held high: done every 19 cycles, with RUN-time start ignored.
    @(negedge clk);
    start = 1'b1;
    a = 16'h0303;
    b = 16'h0105;
    for (int e = 0; e <= 60; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        edges.push_back(e);
        chk("b2b diff", diff, 17'h001FE);
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk("b2b count", edges.size(), 3);
    if (edges.size() >= 3) begin
      chk("b2b first", edges[0], 18);
      chk("b2b period1", edges[1] - edges[0], 19);
      chk("b2b period2", edges[2] - edges[1], 19);
    end
    repeat (25) @(posedge clk);

    // Mixed formats: 1.5 (Q4.4) - 1.0 (Q8.8) = 0.5.
    @(negedge clk);
    start2 = 1'b1;
    a2 = 8'h18;
    b2 = 16'h0100;
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    a2 = 8'hFF;
    b2 = 16'hFFFF;
    seen2 = 1'b0;
    lat2 = 0;
    for (int k = 1; k <= 40 && !seen2; k++) begin
      @(posedge clk);
      #1;
      if (done2) begin
        seen2 = 1'b1;
        lat2 = k;
      end
    end
    chk("mixed latency", lat2, 18);
    chk("mixed diff", diff2, 17'h00080);
    chk("mixed neg", neg2, 1'b0);
    chk("mixed sat", sat2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
